// File: rtl/ula_arbitro.sv
`default_nettype none
// ============================================================================
// Module  : ula_arbitro
// Brief   : Round-robin sequencer sharing one combinational ULA among N_REQ
//           requesters. Define ULA_ARB_OPCHK_EN to reject opcodes 011/101.
// Revision: 1.0 - initial release
// ============================================================================
module ula_arbitro #(
    parameter int WIDTH = 32,
    parameter int N_REQ = 2,
    parameter int ID_W  = 1,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ*3-1:0]     req_op,
    output logic [WIDTH-1:0]       ula_a,
    output logic [WIDTH-1:0]       ula_b,
    output logic [2:0]             ula_control,
    input  logic [WIDTH-1:0]       ula_result,
    input  logic                   ula_zero,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [WIDTH-1:0]       resp_result,
    output logic                   resp_zero,
    output logic                   resp_erro,
    output logic                   busy,
    output logic [CNT_W-1:0]       op_count
);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        EXEC   = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             r_state;
    logic [ID_W-1:0]    r_prio;
    logic [WIDTH-1:0]   r_ula_a;
    logic [WIDTH-1:0]   r_ula_b;
    logic [2:0]         r_ula_control;
    logic               r_resp_valid;
    logic [ID_W-1:0]    r_resp_id;
    logic [WIDTH-1:0]   r_resp_result;
    logic               r_resp_zero;
    logic [CNT_W-1:0]   r_op_count;
`ifdef ULA_ARB_OPCHK_EN
    logic               r_resp_erro;
`endif

    logic               w_found;
    logic [N_REQ-1:0]   w_grant_oh;
    logic [ID_W-1:0]    w_grant_id;
    logic [WIDTH-1:0]   w_grant_a;
    logic [WIDTH-1:0]   w_grant_b;
    logic [2:0]         w_grant_op;
    logic               w_illegal;
    logic [ID_W-1:0]    w_next_prio;

    // Pass 0 scans indices >= prio, pass 1 wraps around to indices < prio.
    always_comb begin
        w_found    = 1'b0;
        w_grant_oh = '0;
        w_grant_id = '0;
        w_grant_a  = '0;
        w_grant_b  = '0;
        w_grant_op = '0;
        for (int p = 0; p < 2; p++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!w_found && req_valid[j] && ((j >= int'(r_prio)) == (p == 0))) begin
                    w_found       = 1'b1;
                    w_grant_oh[j] = 1'b1;
                    w_grant_id    = ID_W'(j);
                    w_grant_a     = req_a[j*WIDTH +: WIDTH];
                    w_grant_b     = req_b[j*WIDTH +: WIDTH];
                    w_grant_op    = req_op[j*3 +: 3];
                end
            end
        end
    end

`ifdef ULA_ARB_OPCHK_EN
    assign w_illegal = (w_grant_op == 3'b011) || (w_grant_op == 3'b101);
    assign resp_erro = r_resp_erro;
`else
    assign w_illegal = 1'b0;
    assign resp_erro = 1'b0;
`endif

    assign w_next_prio = (r_resp_id == ID_W'(N_REQ - 1)) ? '0 : r_resp_id + ID_W'(1);

    assign req_ready   = (rst_n && (r_state == OCIOSO)) ? w_grant_oh : '0;
    assign busy        = (r_state != OCIOSO);
    assign ula_a       = r_ula_a;
    assign ula_b       = r_ula_b;
    assign ula_control = r_ula_control;
    assign resp_valid  = r_resp_valid;
    assign resp_id     = r_resp_id;
    assign resp_result = r_resp_result;
    assign resp_zero   = r_resp_zero;
    assign op_count    = r_op_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= OCIOSO;
            r_prio        <= '0;
            r_ula_a       <= '0;
            r_ula_b       <= '0;
            r_ula_control <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_id     <= '0;
            r_resp_result <= '0;
            r_resp_zero   <= 1'b0;
            r_op_count    <= '0;
`ifdef ULA_ARB_OPCHK_EN
            r_resp_erro   <= 1'b0;
`endif
        end else begin
            case (r_state)
                OCIOSO: begin
                    if (w_found) begin
                        r_resp_id <= w_grant_id;
                        if (w_illegal) begin
                            // Illegal op bypasses the ULA; operand registers keep old values.
                            r_resp_result <= '0;
                            r_resp_zero   <= 1'b0;
                            r_resp_valid  <= 1'b1;
`ifdef ULA_ARB_OPCHK_EN
                            r_resp_erro   <= 1'b1;
`endif
                            r_state       <= RESP;
                        end else begin
                            r_ula_a       <= w_grant_a;
                            r_ula_b       <= w_grant_b;
                            r_ula_control <= w_grant_op;
                            r_state       <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    r_resp_result <= ula_result;
                    r_resp_zero   <= ula_zero;
                    r_resp_valid  <= 1'b1;
`ifdef ULA_ARB_OPCHK_EN
                    r_resp_erro   <= 1'b0;
`endif
                    r_state       <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_prio       <= w_next_prio;
                        r_op_count   <= r_op_count + CNT_W'(1);
                        r_state      <= OCIOSO;
                    end
                end
                default: r_state <= OCIOSO;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ula_arbitro.sv
`default_nettype none
// ============================================================================
// Module  : tb_ula_arbitro
// Brief   : Directed scoreboard bench for ula_arbitro with a behavioural ULA.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ula_arbitro;

    localparam int WIDTH = 32;
    localparam int N_REQ = 2;
    localparam int ID_W  = 1;
    localparam int CNT_W = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ*3-1:0]     req_op;
    logic [WIDTH-1:0]       ula_a;
    logic [WIDTH-1:0]       ula_b;
    logic [2:0]             ula_control;
    logic [WIDTH-1:0]       ula_result;
    logic                   ula_zero;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [ID_W-1:0]        resp_id;
    logic [WIDTH-1:0]       resp_result;
    logic                   resp_zero;
    logic                   resp_erro;
    logic                   busy;
    logic [CNT_W-1:0]       op_count;

    typedef struct packed {
        logic        id;
        logic [31:0] res;
        logic        zero;
        logic        erro;
    } exp_t;

    exp_t     q[$];
    int       vectors    = 0;
    int       miscompares = 0;
    int       tb_prio    = 0;
    int       tb_count   = 0;
    logic [2:0] last_ctrl = 3'b000;

    always #5 clk = ~clk;

    ula_arbitro #(
        .WIDTH (WIDTH),
        .N_REQ (N_REQ),
        .ID_W  (ID_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .ula_a       (ula_a),
        .ula_b       (ula_b),
        .ula_control (ula_control),
        .ula_result  (ula_result),
        .ula_zero    (ula_zero),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .resp_erro   (resp_erro),
        .busy        (busy),
        .op_count    (op_count)
    );

    function automatic logic [31:0] ula_f(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        ula_result = ula_f(ula_control, ula_a, ula_b);
        ula_zero   = (ula_result == 32'd0);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        req_op[i*3 +: 3]   = op;
        req_a[i*32 +: 32]  = a;
        req_b[i*32 +: 32]  = b;
    endtask

    // Called at a negedge with the DUT idle; runs one full transaction.
    task automatic op_step(input logic [1:0] v, input int hold);
        int         g;
        exp_t       e;
        logic [2:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic       ill;
        req_valid = v;
        #1;
        g = v[tb_prio] ? tb_prio : 1 - tb_prio;
        check("grant_onehot", 64'(req_ready), 64'(2'b01 << g));
        op = req_op[g*3 +: 3];
        a  = req_a[g*32 +: 32];
        b  = req_b[g*32 +: 32];
`ifdef ULA_ARB_OPCHK_EN
        ill = (op == 3'b011) || (op == 3'b101);
`else
        ill = 1'b0;
`endif
        e.id = g[0];
        if (ill) begin
            e.res = 32'd0; e.zero = 1'b0; e.erro = 1'b1;
        end else begin
            e.res = ula_f(op, a, b); e.zero = (e.res == 32'd0); e.erro = 1'b0;
        end
        q.push_back(e);
        @(negedge clk);
        if (!ill) begin
            check("exec_busy", 64'(busy), 64'd1);
            check("exec_ready", 64'(req_ready), 64'd0);
            check("exec_resp_valid", 64'(resp_valid), 64'd0);
            check("exec_ula_control", 64'(ula_control), 64'(op));
            check("exec_ula_a", 64'(ula_a), 64'(a));
            check("exec_ula_b", 64'(ula_b), 64'(b));
            last_ctrl = op;
            @(negedge clk);
        end else begin
            check("illegal_ula_hold", 64'(ula_control), 64'(last_ctrl));
        end
        check("resp_valid", 64'(resp_valid), 64'd1);
        e = q.pop_front();
        check("resp_id", 64'(resp_id), 64'(e.id));
        check("resp_result", 64'(resp_result), 64'(e.res));
        check("resp_zero", 64'(resp_zero), 64'(e.zero));
        check("resp_erro", 64'(resp_erro), 64'(e.erro));
        if (hold > 0) begin
            resp_ready = 1'b0;
            repeat (hold) begin
                @(negedge clk);
                check("bp_resp_valid", 64'(resp_valid), 64'd1);
                check("bp_resp_result", 64'(resp_result), 64'(e.res));
                check("bp_resp_id", 64'(resp_id), 64'(e.id));
                check("bp_req_ready", 64'(req_ready), 64'd0);
            end
            resp_ready = 1'b1;
        end
        @(negedge clk);
        tb_prio = (g + 1) % N_REQ;
        tb_count++;
        check("idle_resp_valid", 64'(resp_valid), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("op_count", 64'(op_count), 64'(tb_count % 16));
        req_valid = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ops [5];
        ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
        rst_n      = 1'b0;
        req_valid  = 2'b11;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_op_count", 64'(op_count), 64'd0);
        check("rst_ula_a", 64'(ula_a), 64'd0);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        // add from requester 0 alone
        set_req(0, 3'b010, 32'd5, 32'd7);
        op_step(2'b01, 0);

        // async reset while requester 1 sits in EXEC
        set_req(1, 3'b010, 32'd100, 32'd1);
        req_valid = 2'b10;
        @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'd1);
        req_valid = 2'b11;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_req_ready", 64'(req_ready), 64'd0);
        check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_op_count", 64'(op_count), 64'd0);
        @(negedge clk);
        check("held_rst_resp_valid", 64'(resp_valid), 64'd0);
        rst_n    = 1'b1;
        tb_prio  = 0;
        tb_count = 0;

        // both requesting subtract 9-9: alternating grants, zero set
        set_req(0, 3'b110, 32'd9, 32'd9);
        set_req(1, 3'b110, 32'd9, 32'd9);
        repeat (4) op_step(2'b11, 0);
        check("op_count_after_4", 64'(op_count), 64'd4);

        // backpressure then fairness hand-over
        set_req(0, 3'b001, 32'hF0, 32'h0F);
        set_req(1, 3'b111, 32'hFFFF_FFFE, 32'd3);
        op_step(2'b11, 5);
        op_step(2'b11, 0);

        // opcode 011
        set_req(0, 3'b011, 32'd3, 32'd4);
        op_step(2'b01, 0);

        while (tb_count < 17) begin
            set_req(0, ops[$urandom_range(0, 4)], $urandom, $urandom);
            set_req(1, ops[$urandom_range(0, 4)], $urandom, $urandom);
            op_step(2'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
        end
        check("op_count_wrapped", 64'(op_count), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
